// File: rtl/conf_link_ctrl_if.sv
// Host-side bus between conf_link_ctrl, the RS232 UART and the 88-bit configuration register bank.
interface conf_link_ctrl_if;
  logic [7:0] rx_dw;
  logic       rx_valid;
  logic [7:0] txdw_regs;
  logic       tx_busy;
  logic [7:0] tx_dw;
  logic       tx_start;
  logic       shift_rxregs;
  logic       load_confregs;
  logic       load_txregs;
  logic       shift_txregs;
  logic       frame_err;

  // UART + register bank side
  modport master (
    output rx_dw, rx_valid, txdw_regs, tx_busy,
    input  tx_dw, tx_start, shift_rxregs, load_confregs, load_txregs, shift_txregs, frame_err
  );

  // Sequencer side
  modport slave (
    input  rx_dw, rx_valid, txdw_regs, tx_busy,
    output tx_dw, tx_start, shift_rxregs, load_confregs, load_txregs, shift_txregs, frame_err
  );
endinterface

// File: rtl/conf_link_ctrl.sv
// Command sequencer between the RS232 UART and the configuration register bank.
// Optional write acknowledge is built in when CONF_LINK_ACK_EN is defined.
module conf_link_ctrl #(
  parameter int unsigned NBYTES         = 11,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input logic            clk,
  input logic            rst_n,
  conf_link_ctrl_if.slave link
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NBYTES);
  // Fires one cycle early so frame_err appears exactly TIMEOUT_CYCLES after the last byte
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_DATA   = 3'd1,
    LOAD_CONF = 3'd2,
`ifdef CONF_LINK_ACK_EN
    ACK       = 3'd3,
`endif
    TX_LOAD   = 3'd4,
    TX_SEND   = 3'd5,
    TX_WAIT   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             busy_seen_q, busy_seen_d;
  logic [7:0]       tx_dw_q, tx_dw_d;
  logic             tx_start_q, tx_start_d;
  logic             shift_rx_q, shift_rx_d;
  logic             load_conf_q, load_conf_d;
  logic             load_tx_q, load_tx_d;
  logic             shift_tx_q, shift_tx_d;
  logic             frame_err_q, frame_err_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = '0;
    busy_seen_d = busy_seen_q;
    tx_dw_d     = tx_dw_q;
    tx_start_d  = 1'b0;
    shift_rx_d  = 1'b0;
    load_conf_d = 1'b0;
    load_tx_d   = 1'b0;
    shift_tx_d  = 1'b0;
    frame_err_d = frame_err_q;

    unique case (state_q)
      IDLE: begin
        if (link.rx_valid) begin
          if (link.rx_dw == CMD_WR) begin
            state_d     = RX_DATA;
            cnt_d       = '0;
            frame_err_d = 1'b0;
          end else if (link.rx_dw == CMD_RD) begin
            state_d     = TX_LOAD;
            frame_err_d = 1'b0;
          end
        end
      end

      RX_DATA: begin
        if (link.rx_valid) begin
          shift_rx_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = LOAD_CONF;
          end
        end else if (tmr_q == TMR_FIRE) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      LOAD_CONF: begin
        load_conf_d = 1'b1;
`ifdef CONF_LINK_ACK_EN
        state_d     = ACK;
`else
        state_d     = IDLE;
`endif
      end

`ifdef CONF_LINK_ACK_EN
      ACK: begin
        if (!link.tx_busy) begin
          tx_dw_d    = ACK_BYTE;
          tx_start_d = 1'b1;
          state_d    = IDLE;
        end
      end
`endif

      TX_LOAD: begin
        load_tx_d = 1'b1;
        cnt_d     = '0;
        state_d   = TX_SEND;
      end

      // Hold off while a bank strobe is in flight so txdw_regs is current when latched
      TX_SEND: begin
        if (!link.tx_busy && !load_tx_q && !shift_tx_q) begin
          tx_dw_d     = link.txdw_regs;
          tx_start_d  = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = TX_WAIT;
        end
      end

      TX_WAIT: begin
        if (link.tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          busy_seen_d = 1'b0;
          shift_tx_d  = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = (cnt_q == CNT_LAST) ? IDLE : TX_SEND;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      busy_seen_q <= 1'b0;
      tx_dw_q     <= '0;
      tx_start_q  <= 1'b0;
      shift_rx_q  <= 1'b0;
      load_conf_q <= 1'b0;
      load_tx_q   <= 1'b0;
      shift_tx_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      busy_seen_q <= busy_seen_d;
      tx_dw_q     <= tx_dw_d;
      tx_start_q  <= tx_start_d;
      shift_rx_q  <= shift_rx_d;
      load_conf_q <= load_conf_d;
      load_tx_q   <= load_tx_d;
      shift_tx_q  <= shift_tx_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign link.tx_dw         = tx_dw_q;
  assign link.tx_start      = tx_start_q;
  assign link.shift_rxregs  = shift_rx_q;
  assign link.load_confregs = load_conf_q;
  assign link.load_txregs   = load_tx_q;
  assign link.shift_txregs  = shift_tx_q;
  assign link.frame_err     = frame_err_q;

  // Bank strobes never overlap and the byte counter stays in range
  a_strobe_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({shift_rx_q, load_conf_q, load_tx_q, shift_tx_q}));
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_MAX);

endmodule
